// File: rtl/icap_bitstream_writer.sv
// Streams bitstream words from a valid/ready source into the 7-series ICAP write port.
// Data path: a small FIFO, a one-word head register, then the registered ICAP outputs.
module icap_bitstream_writer #(
  parameter int STATICWIDTH = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [23:0]            word_count,
  input  logic [STATICWIDTH-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [STATICWIDTH-1:0] icap_i,
  output logic                   icap_csib,
  output logic                   icap_rdwrb,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [23:0]            words_written
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  // ICAP expects the bits of every byte reversed while the byte order is kept.
  function automatic logic [STATICWIDTH-1:0] bit_swap(input logic [STATICWIDTH-1:0] w);
    logic [STATICWIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < STATICWIDTH / 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*k+j] = w[8*k+7-j];
      end
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [STATICWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            cnt_q, cnt_d;
  logic [STATICWIDTH-1:0] head_q;
  logic                   head_vld_q, head_vld_d;
  logic [23:0]            rem_in_q, rem_in_d, rem_out_q, rem_out_d, ww_q, ww_d;
  logic [TW-1:0]          to_q, to_d;
  logic [STATICWIDTH-1:0] icap_q, icap_d;
  logic                   csib_q, csib_d, rdwrb_q, rdwrb_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   accept_s, ready_s, push_s, pop_s, mem_pop_s, flush_s;

  assign accept_s  = (state_q == S_IDLE) && start;
  assign ready_s   = (state_q == S_WRITE) && (cnt_q != DEPTH_C) && (rem_in_q != 24'd0);
  assign push_s    = ready_s && s_valid;
  assign pop_s     = (state_q == S_WRITE) && head_vld_q;
  // The head register refills from the FIFO in the same cycle it is drained.
  assign mem_pop_s = (state_q == S_WRITE) && (cnt_q != (AW + 1)'(0)) && (!head_vld_q || pop_s);
  assign flush_s   = (state_q == S_ERROR) || (state_q == S_DONE);

  // FIFO storage, written without reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // FIFO occupancy and head register next state.
  always_comb begin
    cnt_d      = cnt_q;
    head_vld_d = head_vld_q;
    if (flush_s) begin
      cnt_d      = '0;
      head_vld_d = 1'b0;
    end else begin
      case ({push_s, mem_pop_s})
        2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (mem_pop_s) begin
        head_vld_d = 1'b1;
      end else if (pop_s) begin
        head_vld_d = 1'b0;
      end else begin
        head_vld_d = head_vld_q;
      end
    end
  end

  // FIFO pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      if (flush_s) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_s)    wr_ptr_q <= wr_ptr_q + AW'(1);
        if (mem_pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      if (mem_pop_s) head_q <= mem_q[rd_ptr_q];
    end
  end

  // Transfer control, counters and registered-output next state.
  always_comb begin
    state_d   = state_q;
    rem_in_d  = rem_in_q;
    rem_out_d = rem_out_q;
    ww_d      = ww_q;
    to_d      = to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_in_d  = word_count;
          rem_out_d = word_count;
          ww_d      = 24'd0;
          to_d      = '0;
          state_d   = (word_count == 24'd0) ? S_DONE : S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (push_s) begin
          rem_in_d = rem_in_q - 24'd1;
        end else begin
          rem_in_d = rem_in_q;
        end
        if (pop_s) begin
          rem_out_d = rem_out_q - 24'd1;
          ww_d      = ww_q + 24'd1;
          to_d      = '0;
        end else if (rem_out_q == 24'd0) begin
          state_d = S_DONE;
        end else if (to_q == TO_LAST_C) begin
          state_d = S_ERROR;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Empty cycles keep the last word on the bus with chip select released.
    icap_d  = pop_s ? bit_swap(head_q) : icap_q;
    csib_d  = !pop_s;
    rdwrb_d = (state_d != S_WRITE);
    busy_d  = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    if (accept_s) begin
      err_d = 1'b0;
    end else if (state_d == S_ERROR) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_in_q  <= 24'd0;
      rem_out_q <= 24'd0;
      ww_q      <= 24'd0;
      to_q      <= '0;
      icap_q    <= '0;
      csib_q    <= 1'b1;
      rdwrb_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_in_q  <= rem_in_d;
      rem_out_q <= rem_out_d;
      ww_q      <= ww_d;
      to_q      <= to_d;
      icap_q    <= icap_d;
      csib_q    <= csib_d;
      rdwrb_q   <= rdwrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready       = ready_s;
  assign icap_i        = icap_q;
  assign icap_csib     = csib_q;
  assign icap_rdwrb    = rdwrb_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_icap_bitstream_writer.sv
// Scoreboard bench: accepted beats are turned into expected ICAP words by a byte-wise
// bit-reversal model; a monitor pops and compares every csib=0 cycle.
module tb_icap_bitstream_writer;
  localparam int TO = 16;
  typedef logic [31:0] wq_t[$];

  logic        clk, rst, start;
  logic [23:0] word_count;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] icap_i;
  logic        icap_csib, icap_rdwrb, busy, done, error;
  logic [23:0] words_written;

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, first_acc = -1, first_low = -1, last_low = -1;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  icap_bitstream_writer #(.STATICWIDTH(32), .FIFO_DEPTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .icap_i(icap_i), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reverse all 32 bits, then restore the byte order: each byte ends up bit-reversed in place.
  function automatic logic [31:0] ref_swap(input logic [31:0] w);
    logic [31:0] r;
    r = {<<{w}};
    return {<<8{r}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare presented ICAP words, then record newly accepted beats.
  always @(negedge clk) begin
    if (!rst) begin
      if (!icap_csib) begin
        if (first_low < 0) first_low = cyc;
        last_low = cyc;
        obs_q.push_back(icap_i);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%08h required=none", icap_i);
        end else begin
          chk("icap_word", icap_i, exp_q.pop_front());
        end
        chk("icap_rdwrb", 32'(icap_rdwrb), 32'd0);
      end
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc + 1;
        exp_q.push_back(ref_swap(s_data));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    first_acc = -1;
    first_low = -1;
    last_low  = -1;
  endtask

  task automatic start_xfer(input int n);
    start      = 1'b1;
    word_count = 24'(n);
    tick();
    start      = 1'b0;
  endtask

  task automatic rand_words(input int n, output wq_t q);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endtask

  // mode 0: valid held high; mode 1: valid pattern 1,0,0,1 repeating.
  task automatic feed(input wq_t words, input int mode, input int limit,
                      output int sent, output bit busy_low);
    int idx = 0;
    sent = 0;
    busy_low = 1'b0;
    for (int c = 0; c < limit && idx < words.size(); c++) begin
      s_valid = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      s_data  = words[idx];
      @(negedge clk);
      if (!busy) busy_low = 1'b1;
      if (s_valid && s_ready) begin
        idx++;
        sent++;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input int base, input int limit, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done || error || done_cnt > base) begin
        at_cyc = cyc;
        break;
      end
    end
    chk("end_reached", 32'(at_cyc >= 0), 32'd1);
    tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_csib"}, 32'(icap_csib), 32'd1);
    chk({tag, "_rdwrb"}, 32'(icap_rdwrb), 32'd1);
    chk({tag, "_icap_i"}, icap_i, 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    wq_t q, q2, sync_q;
    logic [31:0] gold [4];
    int sent, base, endc;
    bit bl;

    rst = 1'b1; start = 1'b0; word_count = 24'd0; s_data = 32'd0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk) rst = 1'b0;
    tick();

    // Sync sequence with known swapped values.
    sync_q = '{32'hFFFFFFFF, 32'h000000BB, 32'h11220044, 32'hAA995566};
    gold   = '{32'hFFFFFFFF, 32'h000000DD, 32'h88440022, 32'h5599AA66};
    clear_obs();
    base = done_cnt;
    start_xfer(4);
    chk("sync_busy", 32'(busy), 32'd1);
    feed(sync_q, 0, 20, sent, bl);
    chk("sync_sent", 32'(sent), 32'd4);
    wait_end(base, 50, endc);
    repeat (3) tick();
    chk("sync_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) chk("sync_gold", obs_q[i], gold[i]);
    end
    chk("sync_latency", 32'(first_low - first_acc), 32'd2);
    chk("sync_consecutive", 32'(last_low - first_low), 32'd3);
    chk("sync_done_once", 32'(done_cnt - base), 32'd1);
    chk("sync_words", 32'(words_written), 32'd4);
    chk("sync_idle_busy", 32'(busy), 32'd0);

    // Backpressure: 41 words offered, only 40 may be taken.
    rand_words(41, q);
    clear_obs();
    base = done_cnt;
    start_xfer(40);
    feed(q, 0, 70, sent, bl);
    chk("bp_sent", 32'(sent), 32'd40);
    wait_end(base, 50, endc);
    repeat (2) tick();
    chk("bp_count", 32'(obs_q.size()), 32'd40);
    chk("bp_words", 32'(words_written), 32'd40);
    chk("bp_done_once", 32'(done_cnt - base), 32'd1);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Bubbles in the source stream.
    rand_words(12, q);
    clear_obs();
    base = done_cnt;
    start_xfer(12);
    feed(q, 1, 80, sent, bl);
    chk("bub_sent", 32'(sent), 32'd12);
    chk("bub_busy_low", 32'(bl), 32'd0);
    wait_end(base, 50, endc);
    repeat (2) tick();
    chk("bub_count", 32'(obs_q.size()), 32'd12);
    chk("bub_words", 32'(words_written), 32'd12);
    chk("bub_done_once", 32'(done_cnt - base), 32'd1);

    // Underrun: 2 of 5 words, then the source goes quiet.
    rand_words(2, q);
    clear_obs();
    base = done_cnt;
    start_xfer(5);
    feed(q, 0, 10, sent, bl);
    wait_end(base, 100, endc);
    chk("ur_error", 32'(error), 32'd1);
    chk("ur_delay", 32'(endc - last_low), 32'(TO));
    chk("ur_words", 32'(words_written), 32'd2);
    chk("ur_no_done", 32'(done_cnt - base), 32'd0);
    repeat (5) tick();
    chk("ur_sticky", 32'(error), 32'd1);
    chk("ur_busy", 32'(busy), 32'd0);

    // Zero-length transfer; its start also clears the sticky error.
    clear_obs();
    start_xfer(0);
    chk("zero_err_clr", 32'(error), 32'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_csib", 32'(icap_csib), 32'd1);
    tick();
    chk("zero_done_end", 32'(done), 32'd0);
    chk("zero_no_word", 32'(obs_q.size()), 32'd0);

    // Start pulsed while busy is ignored.
    rand_words(6, q);
    q2.delete();
    for (int i = 3; i < 6; i++) q2.push_back(q[i]);
    for (int i = 0; i < 3; i++) void'(q.pop_back());
    clear_obs();
    base = done_cnt;
    start_xfer(6);
    feed(q, 0, 10, sent, bl);
    start_xfer(2);
    feed(q2, 0, 10, sent, bl);
    wait_end(base, 50, endc);
    repeat (2) tick();
    chk("sb_words", 32'(words_written), 32'd6);
    chk("sb_count", 32'(obs_q.size()), 32'd6);
    chk("sb_done_once", 32'(done_cnt - base), 32'd1);

    // Reset in the middle of a transfer, then a fresh transfer.
    rand_words(3, q);
    start_xfer(8);
    feed(q, 0, 10, sent, bl);
    chk("mid_csib_active", 32'(icap_csib), 32'd0);
    rst = 1'b1;
    #1;
    check_reset("mid");
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    tick();
    rand_words(3, q);
    clear_obs();
    base = done_cnt;
    start_xfer(3);
    feed(q, 0, 10, sent, bl);
    wait_end(base, 50, endc);
    repeat (2) tick();
    chk("post_words", 32'(words_written), 32'd3);
    chk("post_count", 32'(obs_q.size()), 32'd3);
    chk("post_done_once", 32'(done_cnt - base), 32'd1);
    chk("post_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icap_bitstream_writer.md
Name: icap_bitstream_writer

Overview:
- Streams partial-bitstream words into the 7-series ICAP primitive so a reconfigurable module (ADD, SUB, MUL, ...) can be swapped at run time.
- Accepts 32-bit words over a valid/ready stream sourced from the PS (AXI GP0 / DMA0 path) and buffers them in an internal FIFO.
- Bit-swaps each byte as ICAP requires, then drives the ICAP write interface; its icap_i output feeds the 32-bit ICAP data input used by the DPR top.
- Reports busy, done, error (underrun timeout) and a word count back to software.

Parameters:
- STATICWIDTH, 32, ICAP/stream data width; only 32 is supported.
- FIFO_DEPTH, 16, internal FIFO depth in words; must be a power of two, at least 4.
- TIMEOUT, 1024, consecutive empty-FIFO cycles in WRITE before ERROR; at least 2.

Ports:
- clk  in  1  single clock for all logic (FCLK_CLK0 domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a transfer of word_count words. Ignored unless state is IDLE.
- word_count  in  24  number of words to transfer; sampled on an accepted start.
- s_data  in  32  bitstream word, byte order as stored in the .bin file.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  block accepts s_data this cycle.
- icap_i  out  32  bit-swapped data to the ICAP I port.
- icap_csib  out  1  ICAP chip select, active low.
- icap_rdwrb  out  1  ICAP direction; 0 = write.
- busy  out  1  high from accepted start until DONE or ERROR is reached.
- done  out  1  one-cycle pulse after the final word is written.
- error  out  1  sticky; set on underrun timeout, cleared by the next accepted start.
- words_written  out  24  count of words presented to ICAP in the current or last transfer.

Behaviour:
- Reset (async, any state): state=IDLE, FIFO emptied.
  - Outputs: icap_csib=1, icap_rdwrb=1, icap_i=0, s_ready=0, busy=0, done=0, error=0, words_written=0.
  - A transfer in flight is abandoned; the ICAP sees csib rise at reset assertion.
- States: IDLE, WRITE, DONE, ERROR.
- IDLE:
  - s_ready=0, icap_csib=1.
  - On start, latch word_count into remaining_in and remaining_out, clear words_written and error, set busy.
  - If word_count==0, go directly to DONE; otherwise go to WRITE.
- Input side (WRITE only):
  - s_ready = (FIFO not full) && (remaining_in != 0).
  - A beat is accepted when s_valid && s_ready; remaining_in decrements on each accepted beat.
  - Words beyond word_count are never accepted.
- Output side (WRITE):
  - If the FIFO is non-empty, pop one word per cycle and register the outputs next edge: icap_i=swap(word), icap_csib=0, icap_rdwrb=0.
  - remaining_out decrements and words_written increments per pop.
  - If the FIFO is empty, register icap_csib=1 and hold icap_rdwrb=0 and icap_i unchanged.
  - Throughput is 1 word/cycle sustained.
- Latency: a word accepted at edge N into an empty FIFO appears on icap_i with csib=0 after edge N+2.
- Swap: icap_i[8k+j] = word[8k+7-j] for k=0..3, j=0..7. Example: 0xAA995566 -> 0x5599AA66.
- Simultaneous FIFO push and pop in the same cycle is legal; the occupancy count is unchanged. Full blocks push only; empty blocks pop only.
- Timeout: a counter increments on each WRITE cycle where the FIFO is empty and remaining_out!=0; it resets on any pop.
  - When the counter reaches TIMEOUT, go to ERROR.
- Completion: when remaining_out reaches 0 after a pop, go to DONE on the next edge.
  - The last word's csib=0 cycle still occurs; csib=1 follows.
- DONE (one cycle):
  - done=1, busy=0, icap_csib=1, icap_rdwrb=1, then return to IDLE.
  - words_written holds its value.
- ERROR (one cycle):
  - error=1 (sticky), busy=0, icap_csib=1, icap_rdwrb=1, FIFO flushed, then return to IDLE.
- start while busy: ignored, with no effect on any counter.

Test Plan:
- Reset mid-transfer: word_count=8, push 3 words, assert rst -> icap_csib=1 immediately; all outputs return to reset values; a new start then transfers from an empty FIFO.
- Sync sequence: start word_count=4, stream 0xFFFFFFFF, 0x000000BB, 0x11220044, 0xAA995566 back-to-back -> icap_i = 0xFFFFFFFF, 0x000000DD, 0x88440022, 0x5599AA66 on 4 consecutive csib=0 cycles; first word appears 2 cycles after acceptance; done pulses once; words_written=4.
- Backpressure: word_count=40, s_valid held high, source never stalls -> FIFO never overflows, s_ready drops only when full or after the 40th beat; 40 words in order; the 41st offered word is not accepted.
- Bubbles: s_valid toggles 1,0,0,1 per cycle -> icap_csib=1 exactly during gap cycles; no word duplicated or dropped; busy stays high.
- Underrun: TIMEOUT=16, word_count=5, supply 2 words then stop -> ERROR after 16 empty cycles; error=1 sticky, done never pulses, words_written=2; the next start clears error.
- Edge cases: word_count=0 gives done one cycle after start with no csib=0 cycle; start pulsed while busy leaves the transfer unchanged.
